gate_arbiter: RTL and testbench
===============================

# gate_arbiter

Shares one barrier gate between NREQ independent requesters (readers/lanes), arbitrates round-robin, and sequences the gate drive through raise, lower and guard phases. Drives the same one-hot gate control code as the gate controller (001 stop, 010 go high, 100 go low) and sits between the requester front-ends and the gate driver. It also validates commands, handshakes each requester, and provides an emergency abort.

## Interface
- NREQ, 4: number of requesters (2..8)
- OPEN_CYC, 6: cycles in RAISE for a single-pass command
- CLOSE_CYC, 6: cycles in LOWER
- GUARD_CYC, 2: cycles in GUARD (stop) before re-arbitration
- CW, 8: phase counter width; 2*OPEN_CYC, CLOSE_CYC, GUARD_CYC must be ≤ 2^CW−1; all cycle parameters ≥ 1

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a pending command
- req_cmd  in  32*NREQ  command of requester i at bits [32i+31:32i]
- abort  in  1  emergency stop request, level
- req_ack  out  NREQ  one-cycle pulse: command of requester i accepted
- req_err  out  NREQ  one-cycle pulse: command of requester i rejected
- ctrl_out  out  3  001 stop, 010 go high, 100 go low
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  $clog2(NREQ)  index of last granted requester

## Operation
- Reset (rst low, async): state IDLE, ctrl_out 001, req_ack 0, req_err 0, busy 0, grant_id 0, rr pointer 0, counter 0.
- States: IDLE, RAISE, LOWER, GUARD. ctrl_out: IDLE/GUARD 001, RAISE 010, LOWER 100.
- Commands: 1 = SINGLE (RAISE OPEN_CYC cycles); 2 = DOUBLE (RAISE 2*OPEN_CYC cycles); any other value is invalid.
- IDLE, abort low, any req_valid: pick the first valid requester at or after the rr pointer (wrapping). Pointer then moves to winner+1 mod NREQ.
  - Valid cmd: → RAISE, pulse req_ack[winner], grant_id ← winner, counter 0.
  - Invalid cmd: stay IDLE, pulse req_err[winner], grant_id unchanged.
- IDLE with abort high: no grant, no ack/err.
- RAISE: count to phase length − 1, then → LOWER. abort high in RAISE: → LOWER next edge, counter 0.
- LOWER: CLOSE_CYC cycles, then → GUARD. abort ignored (gate already lowering).
- GUARD: GUARD_CYC cycles, then → IDLE.
- Requesters hold req_valid and req_cmd stable until ack or err. Deasserting early drops the request without any response. Inputs are ignored outside IDLE.
- At most one bit of req_ack|req_err is high in any cycle.

## Timing
- All outputs are registered. A grant sampled at edge k gives ctrl_out=010, busy=1 and ack pulse, all visible after edge k.
- SINGLE total: OPEN_CYC + CLOSE_CYC + GUARD_CYC cycles with busy high. The next grant is sampled at the first edge in IDLE, so there is ≥1 IDLE cycle between jobs.
- Error path: err pulse one cycle after sampling, and the next requester can be considered on the following edge.
- Abort during RAISE at edge k: ctrl_out=100 after edge k; LOWER then runs the full CLOSE_CYC.
- Reset mid-operation: ctrl_out returns to 001 immediately (async). A pending ack is lost, and requesters re-present their commands.

## Structure
- Package gate_pkg holds:
  - state enum (IDLE, RAISE, LOWER, GUARD)
  - CTRL_STOP=3'b001, CTRL_HIGH=3'b010, CTRL_LOW=3'b100
  - CMD_SINGLE=32'd1, CMD_DOUBLE=32'd2
- Sub-module rr_arbiter:
  - inputs: NREQ request vector, pointer
  - outputs: one-hot grant and index, combinational
  - the pointer register lives in gate_arbiter

## Test plan
- Reset, then req_valid=0001, cmd0=1, defaults → ack[0] pulse, ctrl_out 010 for 6 cycles, 100 for 6, 001 GUARD 2, busy high 14 cycles, grant_id 0.
- req_valid=1111, all cmd=1, held until ack → grants in order 0,1,2,3, each ack exactly once, ≥1 IDLE cycle between jobs.
- cmd0=7, cmd1=2 both valid → err[0] pulse, no ctrl change; then ack[1] and RAISE lasts 12 cycles.
- abort pulsed 1 cycle at 3rd RAISE cycle → ctrl_out 100 next cycle, LOWER 6 cycles, GUARD, IDLE. abort held high in IDLE with req_valid=0001 → no ack.
- rst driven low in LOWER → ctrl_out 001 and busy 0 without waiting for a clock edge. After release with request held, a fresh ack[0] and full sequence follow.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and encodings for the barrier gate arbiter: FSM states,
// one-hot gate drive codes and the command values requesters may issue.
package gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_LOWER = 2'd2,
    ST_GUARD = 2'd3
  } gate_state_e;

  localparam logic [2:0] CTRL_STOP = 3'b001;
  localparam logic [2:0] CTRL_HIGH = 3'b010;
  localparam logic [2:0] CTRL_LOW  = 3'b100;

  localparam logic [31:0] CMD_SINGLE = 32'd1;
  localparam logic [31:0] CMD_DOUBLE = 32'd2;

  function automatic logic [2:0] ctrl_for_state(input gate_state_e s);
    logic [2:0] c;
    case (s)
      ST_RAISE: c = CTRL_HIGH;
      ST_LOWER: c = CTRL_LOW;
      default:  c = CTRL_STOP;
    endcase
    return c;
  endfunction

  function automatic logic cmd_is_valid(input logic [31:0] cmd);
    return (cmd == CMD_SINGLE) || (cmd == CMD_DOUBLE);
  endfunction

endpackage

// File: rtl/gate_arbiter_if.sv
// Requester-side bundle of the gate arbiter: request/command inputs,
// per-requester ack/err pulses and the gate drive outputs.
interface gate_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_cmd;
  logic                 abort;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      req_err;
  logic [2:0]           ctrl_out;
  logic                 busy;
  logic [IW-1:0]        grant_id;

  modport master (
    output req_valid, req_cmd, abort,
    input  req_ack, req_err, ctrl_out, busy, grant_id
  );

  modport slave (
    input  req_valid, req_cmd, abort,
    output req_ack, req_err, ctrl_out, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_sel [NREQ];

  // w_rot[k] is the request sitting k places after the pointer
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IW:0] w_pos;
    assign w_pos     = {1'b0, i_ptr} + (IW+1)'(gi);
    assign w_sel[gi] = (w_pos >= (IW+1)'(NREQ)) ? IW'(w_pos - (IW+1)'(NREQ))
                                                 : IW'(w_pos);
    assign w_rot[gi] = i_req[w_sel[gi]];
  end

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        o_idx   = w_sel[k];
      end
    end
    o_grant = '0;
    if (o_valid) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin owner of a single barrier gate: grants one requester at a time
// and sequences the gate drive through raise, lower and guard phases.
module gate_arbiter
  import gate_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int OPEN_CYC  = 6,
  parameter int CLOSE_CYC = 6,
  parameter int GUARD_CYC = 2,
  parameter int CW        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  localparam logic [CW-1:0] RAISE1_LAST = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] RAISE2_LAST = CW'(2 * OPEN_CYC - 1);
  localparam logic [CW-1:0] LOWER_LAST  = CW'(CLOSE_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYC - 1);

  gate_state_e     r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant_id;
  logic            r_double;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;
  logic [2:0]      r_ctrl;
  logic            r_busy;

  gate_state_e     w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [IW-1:0]   w_ptr_next;
  logic [IW-1:0]   w_grant_id_next;
  logic            w_double_next;
  logic [NREQ-1:0] w_ack_next;
  logic [NREQ-1:0] w_err_next;
  logic [2:0]      w_ctrl_next;
  logic            w_busy_next;

  logic [NREQ-1:0] w_arb_grant;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic [31:0]     w_cmd;
  logic [CW-1:0]   w_raise_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_idx == IW'(i)) w_cmd = bus.req_cmd[32*i +: 32];
    end
  end

  assign w_raise_last = r_double ? RAISE2_LAST : RAISE1_LAST;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_ptr_next      = r_ptr;
    w_grant_id_next = r_grant_id;
    w_double_next   = r_double;
    w_ack_next      = '0;
    w_err_next      = '0;

    case (r_state)
      ST_IDLE: begin
        if (!bus.abort && w_arb_valid) begin
          // the pointer advances on rejections too, so a bad command cannot starve others
          w_ptr_next = (w_arb_idx == IW'(NREQ - 1)) ? '0 : w_arb_idx + IW'(1);
          if (cmd_is_valid(w_cmd)) begin
            w_state_next    = ST_RAISE;
            w_cnt_next      = '0;
            w_ack_next      = w_arb_grant;
            w_grant_id_next = w_arb_idx;
            w_double_next   = (w_cmd == CMD_DOUBLE);
          end else begin
            w_err_next = w_arb_grant;
          end
        end
      end
      ST_RAISE: begin
        if (bus.abort || r_cnt == w_raise_last) begin
          w_state_next = ST_LOWER;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_LOWER: begin
        if (r_cnt == LOWER_LAST) begin
          w_state_next = ST_GUARD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // outputs are registered from the next state so they line up with it
    w_ctrl_next = ctrl_for_state(w_state_next);
    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_double   <= 1'b0;
      r_ack      <= '0;
      r_err      <= '0;
      r_ctrl     <= CTRL_STOP;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ptr      <= w_ptr_next;
      r_grant_id <= w_grant_id_next;
      r_double   <= w_double_next;
      r_ack      <= w_ack_next;
      r_err      <= w_err_next;
      r_ctrl     <= w_ctrl_next;
      r_busy     <= w_busy_next;
    end
  end

  assign bus.req_ack  = r_ack;
  assign bus.req_err  = r_err;
  assign bus.ctrl_out = r_ctrl;
  assign bus.busy     = r_busy;
  assign bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: directed scenarios plus a random
// request mix, all checked against a job-level reference model.
module tb_gate_arbiter;

  localparam int N     = 4;
  localparam int OPEN  = 6;
  localparam int CLOSE = 6;
  localparam int GUARD = 2;
  localparam logic [2:0] C_STOP = 3'b001;
  localparam logic [2:0] C_HIGH = 3'b010;
  localparam logic [2:0] C_LOW  = 3'b100;

  // per-cycle trace entry: {busy, any ack/err, ctrl_out}
  typedef logic [4:0] trace_t;
  typedef trace_t     trace_q[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_ptr  = 0;
  int   m_gid  = 0;

  always #5 clk = ~clk;

  gate_arbiter_if #(.NREQ(N)) bus();

  gate_arbiter #(
    .NREQ(N), .OPEN_CYC(OPEN), .CLOSE_CYC(CLOSE), .GUARD_CYC(GUARD), .CW(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  // job seen from the grant cycle through the first idle cycle afterwards
  function automatic trace_q model_job(input int raise_len, input int abort_at);
    trace_q q;
    int nr;
    q  = {};
    nr = (abort_at > 0 && abort_at < raise_len) ? abort_at : raise_len;
    for (int j = 0; j < nr; j++)    q.push_back({1'b1, logic'(j == 0), C_HIGH});
    for (int j = 0; j < CLOSE; j++) q.push_back({1'b1, 1'b0, C_LOW});
    for (int j = 0; j < GUARD; j++) q.push_back({1'b1, 1'b0, C_STOP});
    q.push_back({1'b0, 1'b0, C_STOP});
    return q;
  endfunction

  task automatic capture_job(input int n, input int abort_at, output trace_q obs);
    obs = {};
    for (int j = 0; j < n; j++) begin
      obs.push_back({bus.busy, |(bus.req_ack | bus.req_err), bus.ctrl_out});
      bus.abort = logic'(abort_at > 0 && j == abort_at - 1);
      if (j < n - 1) tick();
    end
    bus.abort = 1'b0;
  endtask

  task automatic set_cmd(input int i, input logic [31:0] c);
    bus.req_cmd[32*i +: 32] = c;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.abort     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ctrl_out !== C_STOP || bus.busy !== 1'b0 || bus.req_ack !== '0 ||
        bus.req_err !== '0 || bus.grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ctrl=%b busy=%b ack=%b err=%b gid=%0d required ctrl=001 busy=0 ack=0 err=0 gid=0",
               bus.ctrl_out, bus.busy, bus.req_ack, bus.req_err, bus.grant_id);
    end
    tick();
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    m_gid = 0;
    tick();
    n_cmp++;
    if (bus.ctrl_out !== C_STOP || bus.busy !== 1'b0 || bus.req_ack !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: ctrl=%b busy=%b ack=%b required ctrl=001 busy=0 ack=0",
               bus.ctrl_out, bus.busy, bus.req_ack);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    trace_q exp, obs;
    int w;
    bus.req_valid = 4'b0001;
    set_cmd(0, 32'd1);
    tick();
    w = winner(4'b0001, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w) || bus.req_err !== '0 || bus.grant_id !== 2'(w)) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b err=%b gid=%0d required ack=%b err=0000 gid=%0d",
               bus.req_ack, bus.req_err, bus.grant_id, 4'(1 << w), w);
    end
    m_gid = w;
    bus.req_valid[w] = 1'b0;
    exp = model_job(OPEN, 0);
    capture_job(exp.size(), 0, obs);
    for (int j = 0; j < exp.size(); j++) begin
      n_cmp++;
      if (obs[j] !== exp[j]) begin
        n_fail++;
        $display("FAIL single_trace[%0d]: got %b required %b", j, obs[j], exp[j]);
      end
    end
    $display("job single req=%0d cmd=1", w);
  endtask

  task automatic test_round_robin();
    trace_q exp, obs;
    int w;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    m_gid = 0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_cmd(i, 32'd1);
    for (int k = 0; k < N; k++) begin
      tick();
      w = winner(bus.req_valid, m_ptr);
      m_ptr = (w + 1) % N;
      n_cmp++;
      if (bus.req_ack !== 4'(1 << w) || bus.grant_id !== 2'(w) || w != k) begin
        n_fail++;
        $display("FAIL rr_ack[%0d]: ack=%b gid=%0d required ack=%b gid=%0d",
                 k, bus.req_ack, bus.grant_id, 4'(1 << k), k);
      end
      m_gid = w;
      bus.req_valid[w] = 1'b0;
      exp = model_job(OPEN, 0);
      capture_job(exp.size(), 0, obs);
      for (int j = 0; j < exp.size(); j++) begin
        n_cmp++;
        if (obs[j] !== exp[j]) begin
          n_fail++;
          $display("FAIL rr_trace[%0d][%0d]: got %b required %b", k, j, obs[j], exp[j]);
        end
      end
      $display("job rr req=%0d cmd=1", w);
    end
    tick();
    n_cmp++;
    if (bus.req_ack !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drained: ack=%b busy=%b required ack=0000 busy=0", bus.req_ack, bus.busy);
    end
  endtask

  task automatic test_error();
    trace_q exp, obs;
    int w;
    bus.req_valid = 4'b0011;
    set_cmd(0, 32'd7);
    set_cmd(1, 32'd2);
    tick();
    w = winner(bus.req_valid, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_err !== 4'(1 << w) || bus.req_ack !== '0 || bus.ctrl_out !== C_STOP ||
        bus.busy !== 1'b0 || bus.grant_id !== 2'(m_gid)) begin
      n_fail++;
      $display("FAIL err_pulse: err=%b ack=%b ctrl=%b busy=%b gid=%0d required err=%b ack=0000 ctrl=001 busy=0 gid=%0d",
               bus.req_err, bus.req_ack, bus.ctrl_out, bus.busy, bus.grant_id, 4'(1 << w), m_gid);
    end
    bus.req_valid[w] = 1'b0;
    $display("job error req=%0d cmd=7", w);
    tick();
    w = winner(bus.req_valid, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w) || bus.req_err !== '0 || bus.grant_id !== 2'(w)) begin
      n_fail++;
      $display("FAIL double_ack: ack=%b err=%b gid=%0d required ack=%b err=0000 gid=%0d",
               bus.req_ack, bus.req_err, bus.grant_id, 4'(1 << w), w);
    end
    m_gid = w;
    bus.req_valid[w] = 1'b0;
    exp = model_job(2 * OPEN, 0);
    capture_job(exp.size(), 0, obs);
    for (int j = 0; j < exp.size(); j++) begin
      n_cmp++;
      if (obs[j] !== exp[j]) begin
        n_fail++;
        $display("FAIL double_trace[%0d]: got %b required %b", j, obs[j], exp[j]);
      end
    end
    $display("job double req=%0d cmd=2", w);
  endtask

  task automatic test_abort();
    trace_q exp, obs;
    int w;
    bus.req_valid = 4'b0001;
    set_cmd(0, 32'd1);
    tick();
    w = winner(bus.req_valid, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w) || bus.grant_id !== 2'(w)) begin
      n_fail++;
      $display("FAIL abort_ack: ack=%b gid=%0d required ack=%b gid=%0d",
               bus.req_ack, bus.grant_id, 4'(1 << w), w);
    end
    m_gid = w;
    bus.req_valid[w] = 1'b0;
    exp = model_job(OPEN, 3);
    capture_job(exp.size(), 3, obs);
    for (int j = 0; j < exp.size(); j++) begin
      n_cmp++;
      if (obs[j] !== exp[j]) begin
        n_fail++;
        $display("FAIL abort_trace[%0d]: got %b required %b", j, obs[j], exp[j]);
      end
    end
    $display("job abort req=%0d abort_at=3", w);
    bus.abort     = 1'b1;
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (bus.req_ack !== '0 || bus.req_err !== '0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle[%0d]: ack=%b err=%b busy=%b required ack=0000 err=0000 busy=0",
                 k, bus.req_ack, bus.req_err, bus.busy);
      end
    end
    bus.abort = 1'b0;
    tick();
    w = winner(bus.req_valid, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w) || bus.grant_id !== 2'(w)) begin
      n_fail++;
      $display("FAIL abort_release_ack: ack=%b gid=%0d required ack=%b gid=%0d",
               bus.req_ack, bus.grant_id, 4'(1 << w), w);
    end
    m_gid = w;
    bus.req_valid[w] = 1'b0;
    exp = model_job(OPEN, 0);
    capture_job(exp.size(), 0, obs);
    for (int j = 0; j < exp.size(); j++) begin
      n_cmp++;
      if (obs[j] !== exp[j]) begin
        n_fail++;
        $display("FAIL abort_release_trace[%0d]: got %b required %b", j, obs[j], exp[j]);
      end
    end
    $display("job after_abort req=%0d cmd=1", w);
  endtask

  task automatic test_reset_mid();
    trace_q exp, obs;
    int w;
    bus.req_valid = 4'b0001;
    set_cmd(0, 32'd1);
    tick();
    w = winner(bus.req_valid, m_ptr);
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w)) begin
      n_fail++;
      $display("FAIL rstmid_ack: ack=%b required ack=%b", bus.req_ack, 4'(1 << w));
    end
    bus.req_valid[w] = 1'b0;
    for (int k = 0; k < OPEN + 2; k++) tick();
    n_cmp++;
    if (bus.ctrl_out !== C_LOW || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_lower: ctrl=%b busy=%b required ctrl=100 busy=1", bus.ctrl_out, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ctrl_out !== C_STOP || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: ctrl=%b busy=%b required ctrl=001 busy=0", bus.ctrl_out, bus.busy);
    end
    bus.req_valid = 4'b0001;
    tick();
    tick();
    n_cmp++;
    if (bus.req_ack !== '0 || bus.ctrl_out !== C_STOP) begin
      n_fail++;
      $display("FAIL rstmid_held: ack=%b ctrl=%b required ack=0000 ctrl=001", bus.req_ack, bus.ctrl_out);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    m_gid = 0;
    tick();
    w = winner(bus.req_valid, m_ptr);
    m_ptr = (w + 1) % N;
    n_cmp++;
    if (bus.req_ack !== 4'(1 << w) || bus.grant_id !== 2'(w)) begin
      n_fail++;
      $display("FAIL rstmid_reack: ack=%b gid=%0d required ack=%b gid=%0d",
               bus.req_ack, bus.grant_id, 4'(1 << w), w);
    end
    m_gid = w;
    bus.req_valid[w] = 1'b0;
    exp = model_job(OPEN, 0);
    capture_job(exp.size(), 0, obs);
    for (int j = 0; j < exp.size(); j++) begin
      n_cmp++;
      if (obs[j] !== exp[j]) begin
        n_fail++;
        $display("FAIL rstmid_trace[%0d]: got %b required %b", j, obs[j], exp[j]);
      end
    end
    $display("job after_reset req=%0d cmd=1", w);
  endtask

  task automatic test_random();
    trace_q      exp, obs;
    logic [N-1:0] m_valid;
    logic [31:0] m_cmd [N];
    int          w, rl, ab, r;
    m_valid = '0;
    for (int i = 0; i < N; i++) m_cmd[i] = 32'd0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
          m_valid[i] = 1'b1;
          r = int'($urandom_range(0, 9));
          m_cmd[i] = (r < 4) ? 32'd1 : (r < 8) ? 32'd2 : $urandom;
        end
      end
      if (m_valid == '0) begin
        w = int'($urandom_range(0, N - 1));
        m_valid[w] = 1'b1;
        m_cmd[w]   = 32'd1;
      end
      bus.req_valid = m_valid;
      for (int i = 0; i < N; i++) set_cmd(i, m_cmd[i]);
      tick();
      w = winner(m_valid, m_ptr);
      m_ptr = (w + 1) % N;
      if (m_cmd[w] == 32'd1 || m_cmd[w] == 32'd2) begin
        n_cmp++;
        if (bus.req_ack !== 4'(1 << w) || bus.req_err !== '0 || bus.grant_id !== 2'(w)) begin
          n_fail++;
          $display("FAIL rand_ack[%0d]: ack=%b err=%b gid=%0d required ack=%b err=0000 gid=%0d",
                   it, bus.req_ack, bus.req_err, bus.grant_id, 4'(1 << w), w);
        end
        m_gid = w;
        m_valid[w] = 1'b0;
        bus.req_valid = m_valid;
        rl = (m_cmd[w] == 32'd2) ? 2 * OPEN : OPEN;
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rl)) : 0;
        exp = model_job(rl, ab);
        capture_job(exp.size(), ab, obs);
        for (int j = 0; j < exp.size(); j++) begin
          n_cmp++;
          if (obs[j] !== exp[j]) begin
            n_fail++;
            $display("FAIL rand_trace[%0d][%0d]: got %b required %b", it, j, obs[j], exp[j]);
          end
        end
        $display("job rand it=%0d req=%0d cmd=%0d abort_at=%0d", it, w, m_cmd[w], ab);
      end else begin
        n_cmp++;
        if (bus.req_err !== 4'(1 << w) || bus.req_ack !== '0 || bus.ctrl_out !== C_STOP ||
            bus.busy !== 1'b0 || bus.grant_id !== 2'(m_gid)) begin
          n_fail++;
          $display("FAIL rand_err[%0d]: err=%b ack=%b ctrl=%b busy=%b gid=%0d required err=%b ack=0000 ctrl=001 busy=0 gid=%0d",
                   it, bus.req_err, bus.req_ack, bus.ctrl_out, bus.busy, bus.grant_id, 4'(1 << w), m_gid);
        end
        m_valid[w] = 1'b0;
        bus.req_valid = m_valid;
        $display("job rand it=%0d req=%0d cmd=%0h rejected", it, w, m_cmd[w]);
      end
    end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
